// File: rtl/uart_beacon_echo.sv
// uart_beacon_echo: periodic beacon sender plus FIFO-buffered echo of received bytes
module uart_beacon_echo #(
    parameter int MSG_LEN       = 21,
    parameter int PERIOD_CYCLES = 27_000_000,
    parameter int FIFO_DEPTH    = 16,
    parameter int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MSG_LEN*8-1:0] msg_data,
    input  logic                 beacon_en,
    input  logic                 echo_en,
    input  logic                 clr_overflow,
    input  logic [7:0]           rx_data,
    input  logic                 rx_data_valid,
    output logic                 rx_data_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic                 overflow,
    output logic [LVL_W-1:0]     fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(MSG_LEN) + 1;
    typedef enum logic [1:0] {IDLE, BEACON, WAIT} state_t;
    state_t               state_q, state_d;
    logic [MSG_LEN*8-1:0] msg_q, msg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [31:0]          wait_cnt_q, wait_cnt_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 overflow_q, overflow_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic                 full, empty, xfer, push, pop, start;

    always_comb begin
        full  = level_q == LVL_W'(FIFO_DEPTH);
        empty = level_q == '0;
        xfer  = tx_valid_q && tx_data_ready;
        push  = rx_data_valid && echo_en && !full;
        pop   = state_q == WAIT && (!tx_valid_q || xfer) && !empty && echo_en;
        // a beacon never preempts an echo byte that is still waiting for its transfer
        start = state_q == IDLE ? beacon_en :
                state_q == WAIT && wait_cnt_q >= 32'(PERIOD_CYCLES - 1) && beacon_en && !tx_valid_q && !pop;
        state_d    = state_q;
        msg_d      = msg_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (start) begin
            state_d    = BEACON;
            msg_d      = msg_data << 8;
            idx_d      = '0;
            tx_data_d  = msg_data[MSG_LEN*8-1 -: 8];
            tx_valid_d = 1'b1;
        end else if (state_q == IDLE) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
        end else if (state_q == BEACON && xfer) begin
            if (idx_q == IDX_W'(MSG_LEN - 1)) begin
                state_d    = WAIT;
                wait_cnt_d = '0;
                tx_valid_d = 1'b0;
            end else begin
                idx_d     = idx_q + 1'b1;
                tx_data_d = msg_q[MSG_LEN*8-1 -: 8];
                msg_d     = msg_q << 8;
            end
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + {31'b0, wait_cnt_q != '1};
            tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
            tx_valid_d = pop || (tx_valid_q && !xfer);
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        overflow_d = (rx_data_valid && echo_en && full) || (overflow_q && !clr_overflow);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign rx_data_ready = !full;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign overflow      = overflow_q;
    assign fifo_level    = level_q;
endmodule
